// File: rtl/clk_div_measure.sv
// clk_div_measure: measures the rise-to-rise period and the high time of a slow
// square wave on clk_in, counted in clk cycles. It also flags lock (two equal
// periods in a row) and a stall timeout. This is the receive-side checker for
// the integer clock divider.
module clk_div_measure #(
    parameter int WIDTH   = 14,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] TO_VAL  = WIDTH'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t           state, state_next;
    logic             sync_ff, s, s_d;
    logic             rise;
    logic [WIDTH-1:0] per_cnt, hi_cnt;
    logic             capture, to_hit;
    logic             have_prev;

    // Bring clk_in into the clk domain, then keep one extra stage for edge detect.
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge value of its neighbour. Blocking assignments here
    // would collapse the synchroniser chain into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= 1'b0;
            s       <= 1'b0;
            s_d     <= 1'b0;
        end else begin
            sync_ff <= clk_in;
            s       <= sync_ff;
            s_d     <= s;
        end
    end

    assign rise = s & ~s_d;

    // Period and high-time counters: restart at 1 on every rise, saturate otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= WIDTH'(1);
            hi_cnt  <= WIDTH'(1);
        end else begin
            if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;
            if (s && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic. A rise always takes priority over the timeout compare.
    // NOTE: every signal driven here is given a default first. A path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        to_hit     = 1'b0;
        case (state)
            IDLE: if (rise) state_next = MEAS;
            MEAS: begin
                if (rise) begin
                    capture = 1'b1;
                end else if (per_cnt == TO_VAL) begin
                    to_hit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers. Results are captured on a MEAS rise. A timeout drops
    // lock and forgets the previous period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
            have_prev <= 1'b0;
        end else begin
            valid <= capture;
            if (capture) begin
                period    <= per_cnt;
                high_time <= hi_cnt;
                locked    <= have_prev && (per_cnt == period);
                have_prev <= 1'b1;
            end else if (to_hit) begin
                locked    <= 1'b0;
                have_prev <= 1'b0;
            end
            if (rise)        timeout <= 1'b0;
            else if (to_hit) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clk_div_measure.sv
// tb_clk_div_measure: drives clk_in as a sequence of (high, low) pulses,
// synchronous to clk. A pulse-level model predicts the ordered list of valid
// and timeout events from pulse lengths alone. A monitor compares each DUT
// event, its values and its spacing in cycles against that list.
module tb_clk_div_measure;

    localparam int WIDTH   = 14;
    localparam int TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_in;
    logic [WIDTH-1:0] period, high_time;
    logic             valid, locked, timeout;

    clk_div_measure #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_in    (clk_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- pulse-level reference model ----------------
    typedef struct {
        bit          is_to;   // 1: timeout event, 0: valid event
        int unsigned per;
        int unsigned hi;
        bit          lck;
        bit          spaced;  // a previous valid in this run fixes the spacing
    } exp_t;

    exp_t        exp_q[$];
    bit          in_run;          // a measured pulse is pending its closing rise
    int unsigned prev_len, prev_h;
    bit          prev_rise_valid;
    bit          run_has_valid;
    int unsigned run_last_p;
    int unsigned last_reported;

    task automatic model_reset();
        in_run          = 0;
        run_has_valid   = 0;
        prev_rise_valid = 0;
        last_reported   = 0;
    endtask

    // Predict what the rise at the start of pulse (h, l) produces, then drive it.
    task automatic send_pulse(input int unsigned h, input int unsigned l);
        exp_t e;
        bit   this_valid;
        this_valid = 0;
        if (in_run) begin
            e.is_to  = 0;
            e.per    = prev_len;
            e.hi     = prev_h;
            e.lck    = run_has_valid && (run_last_p == prev_len);
            e.spaced = prev_rise_valid;
            exp_q.push_back(e);
            run_has_valid = 1;
            run_last_p    = prev_len;
            last_reported = prev_len;
            this_valid    = 1;
        end
        if (h + l > TIMEOUT) begin
            e.is_to  = 1;
            e.per    = last_reported;
            e.hi     = 0;
            e.lck    = 0;
            e.spaced = this_valid;
            exp_q.push_back(e);
            in_run        = 0;
            run_has_valid = 0;
        end else begin
            in_run          = 1;
            prev_len        = h + l;
            prev_h          = h;
            prev_rise_valid = this_valid;
        end
        repeat (h) @(negedge clk) clk_in = 1'b1;
        repeat (l) @(negedge clk) clk_in = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_period"},    period,    0);
        check({tag, "_high_time"}, high_time, 0);
        check({tag, "_valid"},     valid,     0);
        check({tag, "_locked"},    locked,    0);
        check({tag, "_timeout"},   timeout,   0);
    endtask

    // ---------------- monitor ----------------
    int unsigned cyc = 0;
    int unsigned last_valid_cyc = 0;
    bit          started = 0;
    logic        to_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst || !started) begin
            to_prev = 1'b0;
        end else begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_kind_valid", 0, e.is_to);
                    check("period",    period,    e.per);
                    check("high_time", high_time, e.hi);
                    check("locked",    locked,    e.lck);
                    check("timeout_clear", timeout, 0);
                    if (e.spaced) check("valid_spacing", cyc - last_valid_cyc, e.per);
                end
                last_valid_cyc = cyc;
            end
            if (timeout && !to_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_timeout", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_kind_timeout", 1, e.is_to);
                    check("to_period_hold", period, e.per);
                    check("to_locked",      locked, 0);
                    if (e.spaced) check("timeout_spacing", cyc - last_valid_cyc, TIMEOUT);
                end
            end
            to_prev = timeout;
        end
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        clk_in = 1'b0;
        rst    = 1'b0;
        #1 rst = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        started = 1;
        repeat (3) @(negedge clk);

        // Divide-by-10 (5 high / 5 low).
        repeat (6) send_pulse(5, 5);
        // 4 high / 3 low.
        repeat (6) send_pulse(4, 3);
        // Period 10 switching to 12.
        repeat (4) send_pulse(5, 5);
        repeat (3) send_pulse(6, 6);

        // Timeout boundaries: period exactly TIMEOUT is measured, TIMEOUT+1 times out.
        send_pulse(5, 5);
        send_pulse(5, TIMEOUT - 5);
        send_pulse(5, 5);
        send_pulse(5, 5);
        send_pulse(5, TIMEOUT + 195);
        repeat (4) send_pulse(5, 5);
        send_pulse(5, TIMEOUT - 4);
        repeat (3) send_pulse(5, 5);

        // Minimum period 2 (1 high / 1 low).
        repeat (8) send_pulse(1, 1);

        // Reset in the middle of a low phase after lock.
        repeat (6) send_pulse(5, 5);
        repeat (3) @(negedge clk) clk_in = 1'b0;
        check("queue_before_reset", exp_q.size(), 0);
        check("locked_before_reset", locked, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (3) @(negedge clk);
        repeat (3) send_pulse(5, 5);

        // Randomized pulse trains with occasional stalls.
        for (int g = 0; g < 30; g++) begin
            int unsigned h, l, rep;
            h   = $urandom_range(1, 8);
            l   = $urandom_range(1, 8);
            rep = $urandom_range(1, 5);
            for (int r = 0; r < int'(rep); r++) send_pulse(h, l);
            if ($urandom_range(0, 9) == 0) send_pulse(h, TIMEOUT + $urandom_range(1, 40));
        end

        // Close with a stall so the last pulse's event is resolved.
        send_pulse(3, TIMEOUT + 20);
        repeat (10) @(negedge clk);
        check("queue_empty_at_end", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
